// File: rtl/synth_pkg.sv
// rtl/synth_pkg.sv - shared constants, state encoding and wave-code check for the synth command decoder
package synth_pkg;

  localparam logic [7:0] ADDR_WAVE   = 8'h01;
  localparam logic [7:0] ADDR_FREQ   = 8'h02;
  localparam logic [7:0] ADDR_AMP    = 8'h04;
  localparam logic [7:0] COMMIT_BYTE = 8'h00;

  localparam logic [7:0] WAVE_SAW    = 8'h02;
  localparam logic [7:0] WAVE_SQUARE = 8'h03;
  localparam logic [7:0] WAVE_SINE   = 8'h05;

  localparam logic [2:0] RESET_WAVE  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PAYLOAD,
    ST_COMMIT
  } state_t;

  // The whole payload byte is checked, not just the bits that reach o_wave.
  function automatic logic wave_code_ok(input logic [7:0] code);
    return (code == WAVE_SAW) || (code == WAVE_SQUARE) || (code == WAVE_SINE);
  endfunction

endpackage

// File: rtl/synth_timeout.sv
// rtl/synth_timeout.sv - inter-byte idle timer: reload on strobe, count down while enabled, pulse on expiry
module synth_timeout #(
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] count;

  // Combinational so the frame is dropped on the TIMEOUT_CYC-th idle edge; a reload masks it.
  assign expire = en && !load && (count == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= CNT_W'(TIMEOUT_CYC);
    end else if (!en) begin
      count <= '0;
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/synth_cmd_decoder.sv
// rtl/synth_cmd_decoder.sv - byte-frame decoder driving live wave/freq/amp oscillator registers
module synth_cmd_decoder
  import synth_pkg::*;
#(
  parameter int unsigned FREQ_W      = 24,
  parameter int unsigned AMP_W       = 16,
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic              i_clk50mhz,
  input  logic              i_rst_n,
  input  logic              i_rx_valid,
  input  logic [7:0]        i_rx_byte,
  output logic [2:0]        o_wave,
  output logic [FREQ_W-1:0] o_freq,
  output logic [AMP_W-1:0]  o_amp,
  output logic              o_update,
  output logic              o_err
);

  localparam int WIDE_W = (FREQ_W > AMP_W) ? int'(FREQ_W) : int'(AMP_W);
  localparam int STG_W  = (WIDE_W > 16) ? WIDE_W : 16;

  state_t           state;
  logic [7:0]       sel;
  logic [7:0]       cnt;
  logic [STG_W-1:0] staging;
  logic             expire;

  synth_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk   (i_clk50mhz),
    .rst_n (i_rst_n),
    .load  (i_rx_valid),
    .en    (state != ST_IDLE),
    .expire(expire)
  );

  always_ff @(posedge i_clk50mhz) begin
    if (!i_rst_n) begin
      state    <= ST_IDLE;
      sel      <= '0;
      cnt      <= '0;
      staging  <= '0;
      o_wave   <= RESET_WAVE;
      o_freq   <= '0;
      o_amp    <= '0;
      o_update <= 1'b0;
      o_err    <= 1'b0;
    end else begin
      o_update <= 1'b0;
      o_err    <= 1'b0;
      if (i_rx_valid) begin
        unique case (state)
          ST_IDLE: begin
            staging <= '0;
            sel     <= i_rx_byte;
            state   <= ST_PAYLOAD;
            if (i_rx_byte == ADDR_WAVE) begin
              cnt <= 8'd1;
            end else if (i_rx_byte == ADDR_FREQ) begin
              cnt <= 8'(FREQ_W / 8);
            end else if (i_rx_byte == ADDR_AMP) begin
              cnt <= 8'(AMP_W / 8);
            end else begin
              o_err <= 1'b1;
              state <= ST_IDLE;
            end
          end
          ST_PAYLOAD: begin
            staging <= {staging[STG_W-9:0], i_rx_byte};
            cnt     <= cnt - 8'd1;
            if (cnt == 8'd1) begin
              state <= ST_COMMIT;
            end
          end
          ST_COMMIT: begin
            state   <= ST_IDLE;
            staging <= '0;
            if (i_rx_byte == COMMIT_BYTE &&
                (sel != ADDR_WAVE || wave_code_ok(staging[7:0]))) begin
              o_update <= 1'b1;
              if (sel == ADDR_WAVE) begin
                o_wave <= staging[2:0];
              end else if (sel == ADDR_FREQ) begin
                o_freq <= staging[FREQ_W-1:0];
              end else begin
                o_amp <= staging[AMP_W-1:0];
              end
            end else begin
              o_err <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end else if (expire) begin
        o_err   <= 1'b1;
        state   <= ST_IDLE;
        staging <= '0;
        cnt     <= '0;
      end
    end
  end

endmodule

// File: tb/tb_synth_cmd_decoder.sv
// tb/tb_synth_cmd_decoder.sv - scoreboard bench for synth_cmd_decoder with a frame-level reference model
module tb_synth_cmd_decoder;

  localparam int T = 40;

  typedef struct {
    logic        err;
    logic [2:0]  wave;
    logic [23:0] freq;
    logic [15:0] amp;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic [2:0]  wave;
  logic [23:0] freq;
  logic [15:0] amp;
  logic        update;
  logic        err;

  int n_cmp = 0;
  int n_fail = 0;

  ev_t expq[$];
  logic [2:0]  m_wave = 3'd5;
  logic [23:0] m_freq = 24'h0;
  logic [15:0] m_amp = 16'h0;
  logic        rst_q = 1'b0;

  synth_cmd_decoder #(
    .FREQ_W(24),
    .AMP_W(16),
    .TIMEOUT_CYC(T)
  ) dut (
    .i_clk50mhz(clk),
    .i_rst_n   (rst_n),
    .i_rx_valid(rx_valid),
    .i_rx_byte (rx_byte),
    .o_wave    (wave),
    .o_freq    (freq),
    .o_amp     (amp),
    .o_update  (update),
    .o_err     (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rst_q <= rst_n;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Monitor: pops one expectation per pulse; between pulses the live registers must hold.
  initial begin
    logic [2:0]  sh_wave = 3'd5;
    logic [23:0] sh_freq = 24'h0;
    logic [15:0] sh_amp = 16'h0;
    ev_t e;
    forever begin
      @(negedge clk);
      if (!rst_q) begin
        sh_wave = 3'd5; sh_freq = 24'h0; sh_amp = 16'h0;
        check("reset_wave", 32'(wave), 32'd5);
        check("reset_freq", 32'(freq), 32'd0);
        check("reset_amp", 32'(amp), 32'd0);
        check("reset_pulses", {30'd0, update, err}, 32'd0);
      end else if (update || err) begin
        check("update_err_exclusive", 32'(update && err), 32'd0);
        if (expq.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_pulse: got update=%0d err=%0d, required none", update, err);
        end else begin
          e = expq.pop_front();
          check("pulse_kind_err", 32'(err), 32'(e.err));
          check("live_wave", 32'(wave), 32'(e.wave));
          check("live_freq", 32'(freq), 32'(e.freq));
          check("live_amp", 32'(amp), 32'(e.amp));
          sh_wave = e.wave; sh_freq = e.freq; sh_amp = e.amp;
        end
      end else begin
        check("hold_regs", {5'd0, wave, freq} ^ 32'(amp), {5'd0, sh_wave, sh_freq} ^ 32'(sh_amp));
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no end of run, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    tick();
    rx_valid = 1'b0;
    rx_byte  = 8'($urandom);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    m_wave = 3'd5; m_freq = 24'h0; m_amp = 16'h0;
  endtask

  task automatic drain();
    int budget = 0;
    while (expq.size() != 0 && budget < 8) begin
      tick();
      budget++;
    end
    check("pending_events", 32'(expq.size()), 32'd0);
    expq.delete();
  endtask

  function automatic int nbytes(input logic [7:0] addr);
    return (addr == 8'h01) ? 1 : (addr == 8'h02) ? 3 : 2;
  endfunction

  function automatic void push_ev(input logic e);
    ev_t ev;
    ev.err = e; ev.wave = m_wave; ev.freq = m_freq; ev.amp = m_amp;
    expq.push_back(ev);
  endfunction

  // Full frame; long_at selects the byte preceded by a T-1 idle gap (the reload/expiry tie).
  task automatic run_frame(input logic [7:0] addr, input logic [23:0] val,
                           input logic [7:0] commit, input int long_at);
    int n = nbytes(addr);
    logic [7:0] b[$];
    logic ok;
    b.push_back(addr);
    for (int i = 0; i < n; i++) b.push_back(val[8*(n-1-i) +: 8]);
    b.push_back(commit);
    ok = (commit == 8'h00) && (addr != 8'h01 || val[7:0] inside {8'h02, 8'h03, 8'h05});
    for (int i = 0; i < b.size(); i++) begin
      if (i > 0) idle((i == long_at) ? T - 1 : $urandom_range(0, 2));
      if (i == b.size() - 1) begin
        if (ok) begin
          if (addr == 8'h01) m_wave = val[2:0];
          else if (addr == 8'h02) m_freq = val;
          else m_amp = val[15:0];
        end
        push_ev(!ok);
      end
      send_byte(b[i]);
    end
    drain();
  endtask

  task automatic run_timeout(input logic [7:0] addr, input int k);
    send_byte(addr);
    for (int i = 0; i < k; i++) begin
      idle($urandom_range(0, 2));
      send_byte(8'($urandom));
    end
    idle(T - 1);
    push_ev(1'b1);
    idle(1);
    drain();
  endtask

  task automatic run_reset_mid(input logic [7:0] addr, input int k);
    send_byte(addr);
    for (int i = 0; i < k; i++) send_byte(8'($urandom));
    do_reset();
    idle(2);
  endtask

  initial begin
    logic [7:0] addrs[3] = '{8'h01, 8'h02, 8'h04};
    logic [7:0] codes[3] = '{8'h02, 8'h03, 8'h05};
    logic [7:0] a;
    logic [23:0] v;
    logic [7:0] c;
    int kind;
    idle(3);
    rst_n = 1'b1;
    idle(2);

    run_frame(8'h01, 24'h03, 8'h00, -1);
    check("wave_saw_square", 32'(wave), 32'd3);
    run_frame(8'h02, 24'hFFFF00, 8'h00, -1);
    check("freq_ffff00", 32'(freq), 32'hFFFF00);
    run_frame(8'h04, 24'h1357, 8'h00, -1);
    run_frame(8'h04, 24'h1234, 8'h55, -1);
    check("amp_kept", 32'(amp), 32'h1357);
    run_frame(8'h01, 24'h05, 8'h00, -1);
    run_frame(8'h01, 24'h07, 8'h00, -1);
    check("wave_kept_sine", 32'(wave), 32'd5);
    run_timeout(8'h02, 2);
    run_frame(8'h04, 24'hABCD, 8'h00, -1);
    check("amp_abcd", 32'(amp), 32'hABCD);
    run_frame(8'h02, 24'h123456, 8'h00, 2);
    run_frame(8'h04, 24'h0F0F, 8'h00, 3);

    send_byte(8'h02);
    send_byte(8'hAA);
    do_reset();
    push_ev(1'b1);
    send_byte(8'h00);
    drain();
    check("freq_after_reset", 32'(freq), 32'd0);

    for (int it = 0; it < 200; it++) begin
      kind = $urandom_range(0, 9);
      a = addrs[$urandom_range(0, 2)];
      v = 24'($urandom);
      if (a == 8'h01) v = {16'h0, ($urandom_range(0, 4) != 0) ? codes[$urandom_range(0, 2)] : 8'($urandom)};
      else if (a == 8'h04) v = {8'h0, v[15:0]};
      c = 8'h00;
      case (kind)
        5: begin
          c = 8'($urandom_range(1, 255));
          run_frame(a, v, c, -1);
        end
        6: begin
          c = 8'($urandom);
          while (c inside {8'h01, 8'h02, 8'h04}) c = 8'($urandom);
          push_ev(1'b1);
          send_byte(c);
          drain();
        end
        7: run_timeout(a, $urandom_range(0, nbytes(a)));
        8: run_frame(a, v, c, $urandom_range(1, nbytes(a) + 1));
        9: run_reset_mid(a, $urandom_range(0, nbytes(a)));
        default: run_frame(a, v, c, -1);
      endcase
      idle($urandom_range(0, 3));
    end
    check("final_wave", 32'(wave), 32'(m_wave));
    check("final_freq", 32'(freq), 32'(m_freq));
    check("final_amp", 32'(amp), 32'(m_amp));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/synth_cmd_decoder.md
SYNTH_CMD_DECODER -- requirements
Module: synth_cmd_decoder

Interface
REQ-001 SHALL have parameter FREQ_W, default 24, oscillator tuning-word width (multiple of 8).
REQ-002 SHALL have parameter AMP_W, default 16, amplitude width (multiple of 8).
REQ-003 SHALL have parameter TIMEOUT_CYC, default 1_000_000, idle cycles allowed between frame bytes (20 ms at 50 MHz).
REQ-004 SHALL have ports, clock and reset first:
- i_clk50mhz  in  1  sole clock; all logic on its rising edge.
- i_rst_n  in  1  reset; synchronous, active-low.
- i_rx_valid  in  1  one-cycle strobe; a byte is available from the upstream SPI byte receiver.
- i_rx_byte  in  8  received byte; valid only while i_rx_valid=1.
- o_wave  out  3  live waveform code.
- o_freq  out  FREQ_W  live tuning word.
- o_amp  out  AMP_W  live amplitude.
- o_update  out  1  one-cycle pulse on every committed register write.
- o_err  out  1  one-cycle pulse on every rejected frame.

Function
REQ-005 SHALL parse frames of the form: address byte, N payload bytes (MSB first), commit byte 0x00.
REQ-006 SHALL decode addresses as follows:
- 0x01 = WAVE, N=1.
- 0x02 = FREQ, N=FREQ_W/8.
- 0x04 = AMP, N=AMP_W/8.
REQ-007 SHALL use FSM states IDLE, PAYLOAD and COMMIT.
- IDLE: a valid address moves to PAYLOAD with byte counter = N; any other byte pulses o_err and stays in IDLE.
- PAYLOAD: each strobe shifts the byte into a staging register and decrements the counter; at counter=1 the FSM moves to COMMIT.
- COMMIT: byte 0x00 copies staging to the live output and pulses o_update; any other byte pulses o_err and discards staging. Both cases return to IDLE.
REQ-008 SHALL accept only WAVE payload codes 0x02 (saw), 0x03 (square) and 0x05 (sine). Any other WAVE code SHALL be rejected at commit with o_err, and o_wave SHALL be left unchanged.
REQ-009 SHALL load o_wave with payload bits [2:0].
REQ-010 SHALL update live outputs only on a successful commit, never during PAYLOAD.
REQ-011 SHALL, in PAYLOAD or COMMIT, after TIMEOUT_CYC consecutive cycles without i_rx_valid, pulse o_err, discard staging and return to IDLE.
REQ-012 SHALL reload the timeout counter on every strobe. When a strobe and timeout expiry fall on the same cycle, the strobe SHALL win.
REQ-013 SHALL assert o_update and o_err in the cycle after the strobe that causes them (1-cycle latency), and never both in the same cycle.
REQ-014 SHALL ignore i_rx_byte whenever i_rx_valid=0.
REQ-015 SHALL treat a 0x00 byte in IDLE as an invalid address: o_err pulses.
REQ-016 SHALL accept back-to-back strobes on consecutive cycles.

Reset
REQ-017 SHALL, while i_rst_n=0 at a clock edge, force:
- state = IDLE; counters = 0; staging = 0.
- o_wave = 3'd5 (sine); o_freq = 0; o_amp = 0.
- o_update = 0; o_err = 0.
REQ-018 SHALL abandon any frame in progress when reset is asserted mid-frame, without pulsing o_err.

Structure
REQ-019 SHALL place address constants, wave codes, the state enumeration and the reset wave value in a shared package synth_pkg.
REQ-020 SHALL implement the timeout as one sub-module, synth_timeout (load, count, expire pulse).
REQ-021 SHALL contain no clock crossings; the upstream SPI byte receiver delivers i_rx_valid already synchronous to i_clk50mhz.

Verification
REQ-022 Bytes 0x01,0x03,0x00 -> one o_update; o_wave=3'd3.
REQ-023 Bytes 0x02,0xFF,0xFF,0x00,0x00 -> o_freq=24'hFFFF00, one o_update, no o_err.
REQ-024 Bytes 0x04,0x12,0x34,0x55 -> one o_err; o_amp keeps its prior value.
REQ-025 Bytes 0x01,0x07,0x00 -> one o_err; o_wave stays 3'd5.
REQ-026 Byte 0x02 then 2 payload bytes, then silence for TIMEOUT_CYC cycles -> one o_err. A following 0x04,0xAB,0xCD,0x00 -> o_amp=16'hABCD.
REQ-027 Bytes 0x02,0xAA, then i_rst_n=0 for 1 cycle, then 0x00 -> no o_update; o_freq=0; the 0x00 produces o_err.
